// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow square wave
// in system-clock cycles. One-cycle valid strobe per completed period,
// sticky timeout when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    MEASURE
  } state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [1:0]       warm_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] ht_cap_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_time_q;
  logic             valid_q;
  logic             timeout_q;

  logic             rise_c;
  logic             fall_c;
  logic             sync_ready_c;
  logic [WIDTH-1:0] cnt_inc_c;

  assign rise_c    = s2_q & ~s3_q;
  assign fall_c    = ~s2_q & s3_q;
  assign cnt_inc_c = cnt_q + WIDTH'(1);
  // s2 only reflects the real input once the reset zeros have flushed out
  // of the synchronizer; without this a wave already high at reset release
  // would look like a fresh low level followed by a rise.
  assign sync_ready_c = warm_q[1];

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

  // Two-flop synchronizer, edge-history flop and post-reset flush tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      warm_q <= 2'b00;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      warm_q <= {warm_q[0], 1'b1};
    end
  end

  // Measurement FSM, counter, capture and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOW;
      cnt_q       <= '0;
      ht_cap_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        state_q <= WAIT_LOW;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          WAIT_LOW: begin
            cnt_q <= '0;
            if (sync_ready_c && !s2_q) state_q <= ARMED;
          end
          ARMED: begin
            cnt_q <= '0;
            if (rise_c) state_q <= MEASURE;
          end
          MEASURE: begin
            if (fall_c) ht_cap_q <= cnt_inc_c;
            if (rise_c) begin
              // Rise wins over a simultaneous timeout; no dead cycle between periods
              period_q    <= cnt_inc_c;
              high_time_q <= ht_cap_q;
              valid_q     <= 1'b1;
              timeout_q   <= 1'b0;
              cnt_q       <= '0;
            end else if (cnt_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= WAIT_LOW;
            end else begin
              cnt_q <= cnt_inc_c;
            end
          end
          default: begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: scoreboard of expected (period, high_time)
// pushed as each rising edge is driven, popped on every valid strobe.
module tb_clk_period_meter;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 20;

  logic         clk;
  logic         rst;
  logic         en;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  typedef struct {
    int per;
    int ht;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   nvalid = 0;
  int   cyc    = 0;
  int   last_rise = 0;
  int   nv0;
  int   lr;

  clk_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sig_in = 1'b0;
    repeat (n) tick();
  endtask

  // n periods of h high / l low; each rise after the first completes a period
  task automatic drive_stream(input int h, input int l, input int n, input bit push_exp);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      if (i > 0 && push_exp) q.push_back('{h + l, h});
      last_rise = cyc;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (l) tick();
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && valid) begin
      nvalid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("period", period, mon_e.per);
        chk("high_time", high_time, mon_e.ht);
        chk("timeout_on_valid", timeout, 0);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    sig_in = 1'b0;
    repeat (3) tick();
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    idle(5);

    // Divider-8 loopback
    nv0 = nvalid;
    drive_stream(4, 4, 5, 1'b1);
    idle(TO + 10);
    chk("div8_nvalid", nvalid - nv0, 4);
    chk("div8_timeout_after", timeout, 1);

    // Asymmetric duty 3/7
    nv0 = nvalid;
    drive_stream(3, 7, 4, 1'b1);
    idle(TO + 10);
    chk("asym_nvalid", nvalid - nv0, 3);

    // Fastest input: toggle every cycle
    nv0 = nvalid;
    drive_stream(1, 1, 8, 1'b1);
    idle(TO + 10);
    chk("fast_nvalid", nvalid - nv0, 7);

    // Period exactly TIMEOUT: rise wins, no timeout
    nv0 = nvalid;
    drive_stream(10, 10, 3, 1'b1);
    chk("bound_timeout", timeout, 0);
    chk("bound_nvalid", nvalid - nv0, 2);
    idle(TO + 10);

    // Period TIMEOUT+1: always times out, never valid
    nv0 = nvalid;
    drive_stream(10, 11, 3, 1'b0);
    idle(TO + 10);
    chk("over_nvalid", nvalid - nv0, 0);
    chk("over_timeout", timeout, 1);

    // Timeout timing: flag rises exactly TO cycles after the last detected rise
    nv0 = nvalid;
    drive_stream(5, 5, 4, 1'b1);
    lr = last_rise;
    sig_in = 1'b0;
    while (cyc < lr + 3 + int'(TO) - 1) tick();
    chk("to_not_yet", timeout, 0);
    tick();
    chk("to_set", timeout, 1);
    chk("to_nvalid", nvalid - nv0, 3);
    chk("to_period_hold", period, 10);
    idle(5);
    chk("to_sticky", timeout, 1);
    nv0 = nvalid;
    drive_stream(5, 5, 3, 1'b1);
    chk("to_cleared", timeout, 0);
    chk("to_restore_nvalid", nvalid - nv0, 2);
    idle(TO + 10);

    // Enable low mid-stream: outputs hold, measurement re-arms
    nv0 = nvalid;
    drive_stream(3, 5, 3, 1'b1);
    en = 1'b0;
    repeat (5) tick();
    chk("en_hold_period", period, 8);
    chk("en_hold_high_time", high_time, 3);
    chk("en_no_valid", nvalid - nv0, 2);
    en = 1'b1;
    drive_stream(4, 4, 3, 1'b1);
    idle(TO + 10);
    chk("en_nvalid", nvalid - nv0, 4);

    // Input high at reset release: discarded until a low phase and two rises
    rst    = 1'b1;
    sig_in = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    nv0 = nvalid;
    repeat (10) tick();
    chk("hi_rst_timeout", timeout, 0);
    sig_in = 1'b0;
    repeat (6) tick();
    chk("hi_rst_no_valid", nvalid - nv0, 0);
    drive_stream(4, 4, 3, 1'b1);
    idle(TO + 10);
    chk("hi_rst_nvalid", nvalid - nv0, 2);

    // Reset mid-period clears outputs immediately
    drive_stream(5, 5, 3, 1'b1);
    sig_in = 1'b1;
    tick();
    tick();
    chk("pre_rst_period", period, 10);
    chk("pre_rst_qempty", q.size(), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    tick();
    rst = 1'b0;
    idle(5);
    nv0 = nvalid;
    drive_stream(3, 7, 3, 1'b1);
    idle(TO + 10);
    chk("post_rst_nvalid", nvalid - nv0, 2);

    chk("final_qempty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
